// File: rtl/rv32_inst_pack.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word
// and queues the result in a small FIFO with valid/ready on both sides.
module rv32_inst_pack #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [2:0]       I_fmt,
  input  logic [6:0]       I_opcode,
  input  logic [2:0]       I_funct3,
  input  logic [6:0]       I_funct7,
  input  logic [4:0]       I_rd,
  input  logic [4:0]       I_rs1,
  input  logic [4:0]       I_rs2,
  input  logic [31:0]      I_imm,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [31:0]      O_inst,
  output logic             O_err,
  output logic [CNT_W-1:0] O_count
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [31:0] word;
  logic        bad;
  logic        acc;
  logic        push;
  logic        pop;

  assign O_ready = (count_q != CNT_W'(DEPTH));
  assign O_valid = (count_q != '0);
  assign O_inst  = O_valid ? mem_q[rptr_q] : '0;
  assign O_err   = err_q;
  assign O_count = count_q;

  always_comb begin
    word = '0;
    case (I_fmt)
      FMT_R: word = {I_funct7, I_rs2, I_rs1,
                     I_funct3, I_rd, I_opcode};
      FMT_I: word = {I_imm[11:0], I_rs1,
                     I_funct3, I_rd, I_opcode};
      FMT_S: word = {I_imm[11:5], I_rs2, I_rs1,
                     I_funct3, I_imm[4:0], I_opcode};
      FMT_B: word = {I_imm[12], I_imm[10:5],
                     I_rs2, I_rs1, I_funct3,
                     I_imm[4:1], I_imm[11], I_opcode};
      FMT_U: word = {I_imm[31:12], I_rd, I_opcode};
      FMT_J: word = {I_imm[20], I_imm[10:1],
                     I_imm[11], I_imm[19:12],
                     I_rd, I_opcode};
      default: word = '0;
    endcase
  end

  // Branch/jump offsets must be even; odd ones cannot be encoded.
  always_comb begin
    bad = (I_fmt >= 3'd6)
       || (I_opcode[1:0] != 2'b11)
       || (((I_fmt == FMT_B) || (I_fmt == FMT_J))
           && I_imm[0]);
  end

  always_comb begin
    acc  = I_valid && O_ready;
    push = acc && !bad;
    pop  = O_valid && I_ready;
  end

  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    err_d   = acc && bad;
    if (push) begin
      mem_d[wptr_q] = word;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_rv32_inst_pack.sv
// Directed bench for rv32_inst_pack: encodings, fill/drain,
// concurrent push/pop, rejection pulses and mid-stream reset.
module tb_rv32_inst_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_valid;
  logic        O_ready;
  logic [2:0]  I_fmt;
  logic [6:0]  I_opcode;
  logic [2:0]  I_funct3;
  logic [6:0]  I_funct7;
  logic [4:0]  I_rd;
  logic [4:0]  I_rs1;
  logic [4:0]  I_rs2;
  logic [31:0] I_imm;
  logic        O_valid;
  logic        I_ready;
  logic [31:0] O_inst;
  logic        O_err;
  logic [2:0]  O_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] fill_w [5];

  rv32_inst_pack #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .I_valid(I_valid), .O_ready(O_ready),
    .I_fmt(I_fmt), .I_opcode(I_opcode),
    .I_funct3(I_funct3), .I_funct7(I_funct7),
    .I_rd(I_rd), .I_rs1(I_rs1), .I_rs2(I_rs2),
    .I_imm(I_imm), .O_valid(O_valid),
    .I_ready(I_ready), .O_inst(O_inst),
    .O_err(O_err), .O_count(O_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic set_f(input logic [2:0] fmt,
                       input logic [6:0] op,
                       input logic [2:0] f3,
                       input logic [6:0] f7,
                       input logic [4:0] rd,
                       input logic [4:0] rs1,
                       input logic [4:0] rs2,
                       input logic [31:0] imm);
    I_fmt = fmt; I_opcode = op;
    I_funct3 = f3; I_funct7 = f7;
    I_rd = rd; I_rs1 = rs1; I_rs2 = rs2;
    I_imm = imm;
  endtask

  task automatic addi_k(input int k);
    set_f(3'd1, 7'h13, 3'd0, 7'd0,
          5'(k), 5'd0, 5'd0, 32'(k));
  endtask

  function automatic logic [31:0] addi_w(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  task automatic one(input string tag,
                     input logic [31:0] exp);
    I_valid = 1'b1;
    tick();
    I_valid = 1'b0;
    chk({tag, "_valid"}, 32'(O_valid), 32'd1);
    chk({tag, "_inst"}, O_inst, exp);
    tick();
    chk({tag, "_drained"}, 32'(O_count), 32'd0);
  endtask

  task automatic bad_set(input string tag);
    I_valid = 1'b1;
    tick();
    I_valid = 1'b0;
    chk({tag, "_err"}, 32'(O_err), 32'd1);
    chk({tag, "_cnt"}, 32'(O_count), 32'd1);
    tick();
    chk({tag, "_err_off"}, 32'(O_err), 32'd0);
    chk({tag, "_cnt2"}, 32'(O_count), 32'd1);
  endtask

  initial begin
    rst = 1'b1; I_valid = 1'b0; I_ready = 1'b1;
    set_f(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(O_valid), 32'd0);
    chk("rst_err", 32'(O_err), 32'd0);
    chk("rst_inst", O_inst, 32'd0);
    chk("rst_ready", 32'(O_ready), 32'd1);
    chk("rst_count", 32'(O_count), 32'd0);

    set_f(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    one("add", 32'h002081B3);
    set_f(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    one("addi", 32'h00500093);
    set_f(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
          32'h12345000);
    one("lui", 32'h123452B7);
    set_f(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    one("sw", 32'h0020A423);
    set_f(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
          32'hFFFFFFFC);
    one("beq", 32'hFE000EE3);
    set_f(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    one("jal", 32'h008000EF);

    // Fill with backpressure, fifth set stalls.
    fill_w[0] = 32'h00100093; fill_w[1] = 32'h00200113;
    fill_w[2] = 32'h00300193; fill_w[3] = 32'h00400213;
    fill_w[4] = 32'h00500293;
    I_ready = 1'b0;
    I_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      addi_k(k);
      tick();
      chk("fill_cnt", 32'(O_count), 32'(k));
    end
    chk("full_ready", 32'(O_ready), 32'd0);
    chk("full_head", O_inst, fill_w[0]);
    addi_k(5);
    tick();
    chk("stall_cnt", 32'(O_count), 32'd4);
    chk("stall_head", O_inst, fill_w[0]);
    I_ready = 1'b1;
    tick();
    chk("pop1_cnt", 32'(O_count), 32'd3);
    chk("pop1_head", O_inst, fill_w[1]);
    chk("pop1_ready", 32'(O_ready), 32'd1);
    tick();
    I_valid = 1'b0;
    chk("pp_cnt", 32'(O_count), 32'd3);
    chk("pp_head", O_inst, fill_w[2]);
    tick();
    chk("dr3_cnt", 32'(O_count), 32'd2);
    chk("dr3_head", O_inst, fill_w[3]);
    tick();
    chk("dr4_cnt", 32'(O_count), 32'd1);
    chk("dr5_head", O_inst, fill_w[4]);
    tick();
    chk("dr_empty", 32'(O_valid), 32'd0);
    chk("dr_inst0", O_inst, 32'd0);

    // Concurrent push/pop at count=2.
    I_ready = 1'b0;
    I_valid = 1'b1;
    for (int k = 6; k <= 7; k++) begin
      addi_k(k);
      exp_q.push_back(addi_w(k));
      tick();
    end
    chk("cc_cnt0", 32'(O_count), 32'd2);
    I_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addi_k(8 + i);
      exp_q.push_back(addi_w(8 + i));
      void'(exp_q.pop_front());
      tick();
      chk("cc_cnt", 32'(O_count), 32'd2);
      chk("cc_head", O_inst, exp_q[0]);
    end
    I_valid = 1'b0;
    void'(exp_q.pop_front());
    tick();
    chk("cc_tail", O_inst, exp_q[0]);
    tick();
    chk("cc_empty", 32'(O_count), 32'd0);

    // Rejections with one word held.
    I_ready = 1'b0;
    addi_k(9);
    I_valid = 1'b1;
    tick();
    set_f(3'd6, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    bad_set("fmt6");
    set_f(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    bad_set("b_odd");
    set_f(3'd0, 7'h30, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    bad_set("op30");
    chk("err_head", O_inst, addi_w(9));

    // Reset with three words queued.
    I_valid = 1'b1;
    addi_k(10); tick();
    addi_k(11); tick();
    I_valid = 1'b0;
    chk("pre_rst_cnt", 32'(O_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(O_valid), 32'd0);
    chk("mrst_cnt", 32'(O_count), 32'd0);
    chk("mrst_inst", O_inst, 32'd0);
    chk("mrst_ready", 32'(O_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
